// File: rtl/ripple_carry_seq_adder.sv
// Wide adder built from one shared 8-bit ripple-carry slice, one slice per clock.
// The carry is registered between passes and the result is held behind a valid/ready handshake.

module ripple_carry_adder_8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);
  logic [8:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o = c[8];
endmodule

module ripple_carry_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 8;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, part_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       slice_sum;
  logic             slice_cout;

  ripple_carry_adder_8 u_rca (
    .a_i (a_q[7:0]),
    .b_i (b_q[7:0]),
    .c_i (carry_q),
    .s_o (slice_sum),
    .c_o (slice_cout)
  );

  // New slice enters at the top; after NSLICE passes slice 0 has reached bit 0.
  assign part_d = (part_q >> 8) | (WIDTH'(slice_sum) << (WIDTH - 8));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      part_q    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= in1;
          b_q     <= in2;
          carry_q <= cin;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          part_q  <= part_d;
          a_q     <= a_q >> 8;
          b_q     <= b_q >> 8;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(NSLICE - 1)) begin
            sum       <= part_d;
            cout      <= slice_cout;
            out_valid <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_ripple_carry_seq_adder.sv
// Bench for ripple_carry_seq_adder: directed and random checks at WIDTH=32,
// plus streaming runs at WIDTH=8 and WIDTH=64 with out_ready tied high.

module tb_ripple_carry_seq_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0, ntotal = 0, nfail = 0, ndone = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Golden model: exact (WIDTH+1)-bit sum of zero-extended operands.
  function automatic logic [64:0] gold(input logic [63:0] a, input logic [63:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {64'd0, c};
  endfunction

  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [31:0] in1, in2, sum;

  ripple_carry_seq_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic c);
    in1 = a; in2 = b; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c, input bit rnd);
    int n, nb;
    n = 0; nb = 0;
    while (!out_valid && n < 40) begin
      if (busy) nb++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 65'(n), 65'(4));
    check({tag, "_busy_cycles"}, 65'(nb), 65'(4));
    check({tag, "_result"}, 65'({cout, sum}), gold(64'(a), 64'(b), c));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, 65'(out_valid), 65'(1'b0));
    check({tag, "_iready_rise"}, 65'(in_ready), 65'(1'b1));
  endtask

  initial begin
    logic [31:0] a, b;
    logic        c;
    int          seen;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0; cin = 1'b0;

    // reset asserted between clock edges
    #12 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 65'(in_ready), 65'(1'b1));
    check("rst_out_valid", 65'(out_valid), 65'(1'b0));
    check("rst_busy", 65'(busy), 65'(1'b0));
    check("rst_sum", 65'(sum), 65'(0));
    check("rst_cout", 65'(cout), 65'(1'b0));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // carry ripples through all four slices
    check("t2_ready", 65'(in_ready), 65'(1'b1));
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("t2_sum_const", 65'({cout, sum}), 65'h1_0000_0000);
    release_out("t2");

    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_done("t3", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    check("t3_sum_const", 65'({cout, sum}), 65'h0_ACF1_3569);

    // backpressure: new operands presented while the result is stalled
    in1 = 32'h0F0F_0F0F; in2 = 32'hF0F0_F0F1; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_stall_ovalid", 65'(out_valid), 65'(1'b1));
      check("t4_stall_iready", 65'(in_ready), 65'(1'b0));
      check("t4_stall_result", 65'({cout, sum}), gold(64'h1234_5678, 64'h9ABC_DEF0, 1'b1));
    end
    release_out("t4");
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t4_accept_busy", 65'(busy), 65'(1'b1));
    wait_done("t4", 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b1, 1'b0);

    // reset in the middle of a run after two slices
    release_out("t5pre");
    start_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_ovalid", 65'(out_valid), 65'(1'b0));
    check("t5_rst_busy", 65'(busy), 65'(1'b0));
    check("t5_rst_result", 65'({cout, sum}), 65'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("t5_no_ovalid", 65'(seen), 65'(0));
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    wait_done("t5", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("t5_sum_const", 65'({cout, sum}), 65'h0_0001_0000);
    release_out("t5");

    // random operands, random out_ready
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      a = $urandom(); b = $urandom(); c = 1'($urandom());
      if (k % 50 == 0) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c = 1'b1; end
      check("t6_ready", 65'(in_ready), 65'(1'b1));
      start_op(a, b, c);
      wait_done("t6", a, b, c, 1'b1);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (out_ready) break;
        if ({cout, sum} !== 33'(gold(64'(a), 64'(b), c))) seen++;
      end
      out_ready = 1'b0;
      check("t6_hold_stable", 65'(seen), 65'(0));
      check("t6_ovalid_drop", 65'(out_valid), 65'(1'b0));
    end

    for (int k = 0; k < 20000 && ndone < 2; k++) @(posedge clk);
    check("width_runs_done", 65'(ndone), 65'(2));
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  // Streaming runs at other widths: in_valid held high, out_ready tied high.
  for (genvar gi = 0; gi < 2; gi++) begin : g_w
    localparam int W  = (gi == 0) ? 8 : 64;
    localparam int NS = W / 8;
    logic         rst_g_n = 1'b0;
    logic         ird, ov, cy, by;
    logic [W-1:0] ga = '0, gb = '0, gs;
    logic         gc = 1'b0;

    ripple_carry_seq_adder #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_g_n), .in_valid(1'b1), .in_ready(ird),
      .in1(ga), .in2(gb), .cin(gc), .out_valid(ov), .out_ready(1'b1),
      .sum(gs), .cout(cy), .busy(by)
    );

    initial begin
      logic [64:0] q[$];
      int          last, ndn;
      logic        acc;
      last = -1; ndn = 0;
      ga = W'({$urandom(), $urandom()}); gb = W'({$urandom(), $urandom()}); gc = 1'($urandom());
      repeat (2) @(posedge clk);
      #1 rst_g_n = 1'b1;
      for (int cyc = 0; cyc < 200 * (NS + 2); cyc++) begin
        acc = ird;
        @(posedge clk); #1;
        if (acc) begin
          q.push_back(gold(64'(ga), 64'(gb), gc));
          if (last >= 0) check($sformatf("w%0d_period", W), 65'(cyc - last), 65'(NS + 2));
          last = cyc;
          ga = W'({$urandom(), $urandom()}); gb = W'({$urandom(), $urandom()}); gc = 1'($urandom());
          if (cyc % 40 == 0) begin ga = '1; gb = '0; gc = 1'b1; end
        end
        if (ov) begin
          if (q.size() == 0) check($sformatf("w%0d_spurious", W), 65'(1'b1), 65'(1'b0));
          else check($sformatf("w%0d_result", W), 65'({cy, gs}), q.pop_front());
          ndn++;
        end
      end
      check($sformatf("w%0d_completions", W), 65'(ndn >= 190), 65'(1'b1));
      ndone++;
    end
  end
endmodule

// File: doc/ripple_carry_seq_adder.md
Name: ripple_carry_seq_adder

Overview:
Multi-cycle wide adder controller that reuses a single 8-bit ripple carry adder, ripple_carry_adder_8, across WIDTH/8 consecutive cycles. The 8-bit carry-out is registered between slices. Operands enter through a valid/ready handshake, and the result is held until a valid/ready handshake accepts it. It is the area-minimal adder option for the multiplier accumulation path, trading latency for one shared 8-bit datapath.

Parameters:
WIDTH, 32, operand/sum width in bits; must be a multiple of 8 and at least 8.
NSLICE, WIDTH/8, derived localparam, not overridable; number of adder passes per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and cin present
in_ready  output  1  block can accept operands; high iff state is IDLE
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
cin  input  1  carry-in to slice 0
out_valid  output  1  sum/cout hold a completed result not yet accepted
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
cout  output  1  registered final carry
busy  output  1  high in RUN or HOLD

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. Assertion immediately forces state IDLE and clears operand regs, carry reg, slice counter, sum, cout, out_valid and busy. in_ready is 1 during and after reset.
- Datapath: exactly one ripple_carry_adder_8 instance. There is no other adder or "+" operator on the data path. Slice counter width is clog2(NSLICE), minimum 1.
- State IDLE:
  - in_ready=1.
  - On in_valid at a clock edge, capture in1→A, in2→B, cin→carry reg, counter←0, then go to RUN.
  - in_valid low: remain in IDLE.
- State RUN, one adder pass per cycle:
  - Adder inputs are A[7:0], B[7:0] and carry reg.
  - Each edge: partial ← {slice_sum, partial[WIDTH-1:8]}; A and B shift right by 8; carry reg ← adder cout; counter++.
  - On the edge where counter==NSLICE-1: load sum ← {slice_sum, partial[WIDTH-1:8]} and cout ← adder cout, set out_valid=1, go to HOLD.
  - in1, in2, cin and in_valid are ignored in RUN. out_ready has no effect in RUN.
- State HOLD:
  - out_valid=1; sum and cout stable; in_ready=0.
  - On out_valid & out_ready at an edge: out_valid←0, go to IDLE.
  - A new operation is never accepted on the same edge as the output handshake.
- Latency and throughput:
  - Operands accepted at edge E0; out_valid is first high after edge E(NSLICE). WIDTH=32 gives 4 edges; WIDTH=8 gives 1.
  - With out_ready tied high and in_valid held high, operations start every NSLICE+2 cycles (6 for WIDTH=32).
- Arithmetic: {cout,sum} = in1 + in2 + cin, an exact (WIDTH+1)-bit result with no overflow loss.
- Output retention: sum and cout keep the last completed result through IDLE and the next RUN. They change only on a final-slice edge or on reset.
- Boundary: WIDTH=8 takes the RUN → HOLD path after one pass. A carry of 1 must propagate across every slice boundary.
- Reset mid-RUN or mid-HOLD: the operation is aborted and no out_valid is produced. The first post-reset operation must be correct.

Test Plan:
1. Reset with rst_n=0 mid-clock → immediately in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
2. WIDTH=32: in1=0xFFFFFFFF, in2=0x00000001, cin=0 → out_valid high 4 edges after accept; sum=0x00000000, cout=1.
3. in1=0x12345678, in2=0x9ABCDEF0, cin=1 → sum=0xACF13569, cout=0; busy high for exactly 4 cycles before out_valid.
4. Backpressure:
   - Setup: out_ready=0 for 5 cycles after completion, with in_valid=1 carrying new operands.
   - During stall: out_valid, sum and cout stable; in_ready=0; the new operands are not consumed.
   - Release: on out_ready=1, out_valid drops at the next edge and in_ready rises.
   - Then: the new operands are accepted one edge later and give the correct sum.
5. Reset mid-operation: rst_n pulsed low after 2 slices → no out_valid, outputs zero. A following op 0x0000FFFF+0x00000001 gives 0x00010000, cout=0.
6. Randomised run of 1000 ops, out_ready random, compared against a golden (WIDTH+1)-bit model. Also repeated at WIDTH=8 and WIDTH=64; with out_ready tied high, the issue period must be exactly NSLICE+2.
